// File: rtl/rv32i_ctrl_fsm_if.sv
// rv32i_ctrl_fsm_if: handshake and datapath-control bundle between the RV32I
// control sequencer (master) and its IMEM/decoder/ALU/DMEM environment (slave).
// Optional macro CTRL_PERF_CNT_EN adds the instret/cycle_cnt counter outputs.
interface rv32i_ctrl_fsm_if;
  logic        run;
  logic        if_req;
  logic        if_ack;
  logic        ir_write;
  logic        decode;
  logic        id_comp;
  logic        halt;
  logic        branch;
  logic [1:0]  PCsel;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic        br_taken;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        alu_en;
  logic        mem_req;
  logic        mem_ack;
  logic        reg_we;
  logic [31:0] pc;
  logic        halted;
  logic        ctrl_err;
  logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret;
  logic [31:0] cycle_cnt;
`endif

`ifdef CTRL_PERF_CNT_EN
  modport master (
    input  run, if_ack, id_comp, halt, branch, PCsel, regwrite, memread,
           memwrite, br_taken, imm, alu_out, mem_ack,
    output if_req, ir_write, decode, alu_en, mem_req, reg_we, pc, halted,
           ctrl_err, state, instret, cycle_cnt
  );
  modport slave (
    output run, if_ack, id_comp, halt, branch, PCsel, regwrite, memread,
           memwrite, br_taken, imm, alu_out, mem_ack,
    input  if_req, ir_write, decode, alu_en, mem_req, reg_we, pc, halted,
           ctrl_err, state, instret, cycle_cnt
  );
`else
  modport master (
    input  run, if_ack, id_comp, halt, branch, PCsel, regwrite, memread,
           memwrite, br_taken, imm, alu_out, mem_ack,
    output if_req, ir_write, decode, alu_en, mem_req, reg_we, pc, halted,
           ctrl_err, state
  );
  modport slave (
    output run, if_ack, id_comp, halt, branch, PCsel, regwrite, memread,
           memwrite, br_taken, imm, alu_out, mem_ack,
    input  if_req, ir_write, decode, alu_en, mem_req, reg_we, pc, halted,
           ctrl_err, state
  );
`endif
endinterface

// File: rtl/rv32i_ctrl_fsm.sv
// rv32i_ctrl_fsm: multi-cycle RV32I control sequencer. Walks each instruction
// through FETCH, DECODE, DEC_WAIT, EXEC, optional MEM and WB, owns the PC and
// raises sticky halt/error indications.
// Optional macro CTRL_PERF_CNT_EN adds the instret and cycle_cnt counters.
module rv32i_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rv32i_ctrl_fsm_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_DEC_WAIT = 3'd3;
  localparam logic [2:0] S_EXEC     = 3'd4;
  localparam logic [2:0] S_MEM      = 3'd5;
  localparam logic [2:0] S_WB       = 3'd6;
  localparam logic [2:0] S_HALT     = 3'd7;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_pc_next;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_pc_tgt;
  logic             w_misal;
  logic             w_err_set;
  logic             w_pc_latch;
  logic             w_pc_commit;
  logic             w_ir_write;

  logic             r_if_req;
  logic             r_decode;
  logic             r_alu_en;
  logic             r_mem_req;
  logic             r_reg_we;
  logic             r_halted;
  logic             r_ctrl_err;

  // Next-PC selection from decoder PCsel/branch and the ALU compare result
  always_comb begin
    w_pc_plus4 = r_pc + 32'd4;
    w_pc_tgt   = w_pc_plus4;
    case (bus.PCsel)
      2'd1: begin
        if (bus.branch && bus.br_taken) begin
          w_pc_tgt = r_pc + bus.imm;
        end
      end
      2'd2:    w_pc_tgt = {bus.alu_out[31:1], 1'b0};
      default: w_pc_tgt = w_pc_plus4;
    endcase
  end

  // A target with bit1 set is not word aligned and aborts the instruction
  assign w_misal = w_pc_tgt[1];

  // Instruction register loads in the same cycle the IMEM acknowledges
  assign w_ir_write = (r_state == S_FETCH) && bus.if_ack;

  // Next-state logic and per-phase control decisions
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    w_err_set      = 1'b0;
    w_pc_latch     = 1'b0;
    w_pc_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.if_ack) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        if (bus.id_comp) begin
          w_state_nxt = bus.halt ? S_HALT : S_EXEC;
        end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Decoder never completed: flag it and park
          w_err_set   = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (w_misal) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_pc_latch  = 1'b1;
          w_state_nxt = (bus.memread || bus.memwrite) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_pc_commit = 1'b1;
        w_state_nxt = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and DEC_WAIT timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Phase strobes registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_req  <= 1'b0;
      r_decode  <= 1'b0;
      r_alu_en  <= 1'b0;
      r_mem_req <= 1'b0;
      r_reg_we  <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_if_req  <= (w_state_nxt == S_FETCH);
      r_decode  <= (w_state_nxt == S_DECODE);
      r_alu_en  <= (w_state_nxt == S_EXEC);
      r_mem_req <= (w_state_nxt == S_MEM);
      r_reg_we  <= (w_state_nxt == S_WB) && bus.regwrite;
      r_halted  <= (w_state_nxt == S_HALT);
    end
  end

  // Sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_err <= 1'b0;
    end else if (w_err_set) begin
      r_ctrl_err <= 1'b1;
    end
  end

  // PC: target captured in EXEC, committed on the WB exit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_pc_next <= RESET_PC;
    end else begin
      if (w_pc_latch) begin
        r_pc_next <= w_pc_tgt;
      end
      if (w_pc_commit) begin
        r_pc <= r_pc_next;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_instret;
  logic [31:0] r_cycle_cnt;

  // Retired-instruction and active-cycle counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret   <= 32'd0;
      r_cycle_cnt <= 32'd0;
    end else begin
      if (w_pc_commit) begin
        r_instret <= r_instret + 32'd1;
      end
      if ((r_state != S_IDLE) && (r_state != S_HALT)) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
    end
  end

  assign bus.instret   = r_instret;
  assign bus.cycle_cnt = r_cycle_cnt;
`endif

  assign bus.if_req   = r_if_req;
  assign bus.ir_write = w_ir_write;
  assign bus.decode   = r_decode;
  assign bus.alu_en   = r_alu_en;
  assign bus.mem_req  = r_mem_req;
  assign bus.reg_we   = r_reg_we;
  assign bus.pc       = r_pc;
  assign bus.halted   = r_halted;
  assign bus.ctrl_err = r_ctrl_err;
  assign bus.state    = r_state;

endmodule
